// File: rtl/uart_pkg.sv
// Constants and FSM encodings shared by the UART core and its FIFO/handshake controller.
package uart_pkg;

    localparam int FIFO_DEPTH = 4;

    // Baud generation lives in the uart core; kept here so both sides agree on the clock plan.
    localparam int CLK_HZ   = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int BAUD_DIV = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        T_IDLE    = 3'b001,
        T_SEND    = 3'b010,
        T_RELEASE = 3'b100
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b01,
        R_ACK  = 2'b10
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with first-word fall-through read data and a separate count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    // Accept/reject is decided on the registered count only, so a same-cycle
    // pop never makes room for a push on a full FIFO (and vice versa).
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// TX/RX byte buffering between CPU registers and the uart core, with the frame
// (start_tx/tx_done) and receive (rx_available/rx_clear) handshakes.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_wr_en,
    input  logic [7:0]       tx_wr_data,
    output logic             tx_full,
    output logic [CNT_W-1:0] tx_count,
    input  logic             rx_rd_en,
    output logic [7:0]       rx_rd_data,
    output logic             rx_empty,
    output logic [CNT_W-1:0] rx_count,
    output logic             rx_overrun,
    input  logic             rx_ovr_clr,
    output logic             start_tx,
    output logic [7:0]       tx_value,
    input  logic             tx_done,
    input  logic             rx_available,
    input  logic [7:0]       rx_value,
    output logic             rx_clear
);
    tx_state_e  tx_state_q, tx_state_d;
    rx_state_e  rx_state_q, rx_state_d;
    logic       start_tx_q, start_tx_d;
    logic [7:0] tx_value_q, tx_value_d;
    logic       rx_clear_q, rx_clear_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_pop, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_wr_en), .pop(tx_pop), .wr_data(tx_wr_data),
        .rd_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_rd_en), .wr_data(rx_value),
        .rd_data(rx_rd_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // One pop per frame: the byte is latched into tx_value on leaving T_IDLE.
    always_comb begin
        tx_state_d = tx_state_q;
        start_tx_d = start_tx_q;
        tx_value_d = tx_value_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            T_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_value_d = tx_head;
                start_tx_d = 1'b1;
                tx_state_d = T_SEND;
            end
            T_SEND: if (tx_done) begin
                start_tx_d = 1'b0;
                tx_state_d = T_RELEASE;
            end
            T_RELEASE: if (!tx_done) tx_state_d = T_IDLE;
            default: begin
                start_tx_d = 1'b0;
                tx_state_d = T_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_clear_d = rx_clear_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            R_IDLE: if (rx_available) begin
                rx_push    = 1'b1;
                rx_clear_d = 1'b1;
                rx_state_d = R_ACK;
            end
            R_ACK: if (!rx_available) begin
                rx_clear_d = 1'b0;
                rx_state_d = R_IDLE;
            end
            default: begin
                rx_clear_d = 1'b0;
                rx_state_d = R_IDLE;
            end
        endcase
        // A new drop outranks a same-cycle clear.
        if (rx_push && rx_full) rx_overrun_d = 1'b1;
        else if (rx_ovr_clr)    rx_overrun_d = 1'b0;
        else                    rx_overrun_d = rx_overrun_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= T_IDLE;
            rx_state_q   <= R_IDLE;
            start_tx_q   <= 1'b0;
            tx_value_q   <= '0;
            rx_clear_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            rx_state_q   <= rx_state_d;
            start_tx_q   <= start_tx_d;
            tx_value_q   <= tx_value_d;
            rx_clear_q   <= rx_clear_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign start_tx   = start_tx_q;
    assign tx_value   = tx_value_q;
    assign rx_clear   = rx_clear_q;
    assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: behavioural uart model on the TX side, scoreboard queues for both directions.
module tb_uart_fifo_ctrl;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             tx_wr_en, rx_rd_en, rx_ovr_clr, rx_available;
    logic [7:0]       tx_wr_data, rx_value;
    logic             tx_full, rx_empty, rx_overrun, start_tx, rx_clear;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic [7:0]       rx_rd_data, tx_value;
    logic             tx_done = 1'b0;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_count(tx_count),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
        .rx_overrun(rx_overrun), .rx_ovr_clr(rx_ovr_clr),
        .start_tx(start_tx), .tx_value(tx_value), .tx_done(tx_done),
        .rx_available(rx_available), .rx_value(rx_value), .rx_clear(rx_clear)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    logic       exp_ovr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // uart model: raises tx_done 20 cycles into each frame, drops it once start_tx falls.
    logic       uart_block = 1'b0;
    int         tx_cyc = 0;
    int         tx_frames = 0;
    logic [7:0] tx_held = '0;

    always @(posedge clk) begin
        #1;
        if (tx_done && !rst) check("start_drop", 32'(start_tx), 32'd0);
        if (rst || !start_tx) begin
            tx_cyc  = 0;
            tx_done = 1'b0;
        end else if (!uart_block) begin
            if (tx_cyc == 0) begin
                tx_held = tx_value;
                tx_frames++;
                if (tx_exp_q.size() == 0) check("tx_frame_extra", 32'(tx_exp_q.size()), 32'd1);
                else                      check("tx_frame", 32'(tx_value), 32'(tx_exp_q.pop_front()));
            end else begin
                check("tx_hold", 32'(tx_value), 32'(tx_held));
            end
            tx_cyc++;
            if (tx_cyc >= 20) tx_done = 1'b1;
        end
    end

    int   ack_cnt = 0;
    logic clr_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rx_clear && !clr_prev) ack_cnt++;
        clr_prev = rx_clear;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] b);
        tx_wr_en   = 1'b1;
        tx_wr_data = b;
        step();
        tx_wr_en   = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!start_tx && n < 20) begin step(); n++; end
        check(tag, 32'(start_tx), 32'd1);
    endtask

    task automatic wait_tx_drain();
        int n = 0;
        while ((tx_exp_q.size() != 0 || start_tx || tx_done) && n < 500) begin step(); n++; end
        check("tx_drain", 32'(tx_exp_q.size()), 32'd0);
        check("tx_idle", 32'(start_tx), 32'd0);
        step();
        step();
    endtask

    task automatic rx_send(input logic [7:0] b, input int hold);
        rx_available = 1'b1;
        rx_value     = b;
        if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
        else                         exp_ovr = 1'b1;
        step();
        check("rx_clear_hi", 32'(rx_clear), 32'd1);
        check("rx_count_wr", 32'(rx_count), 32'(rx_exp_q.size()));
        for (int i = 1; i < hold; i++) step();
        rx_available = 1'b0;
        step();
        check("rx_clear_lo", 32'(rx_clear), 32'd0);
    endtask

    task automatic rx_read();
        logic [7:0] e;
        e = rx_exp_q.pop_front();
        check("rx_head", 32'(rx_rd_data), 32'(e));
        rx_rd_en = 1'b1;
        step();
        rx_rd_en = 1'b0;
        check("rx_count_rd", 32'(rx_count), 32'(rx_exp_q.size()));
    endtask

    task automatic check_reset_state();
        check("rst_tx_full", 32'(tx_full), 32'd0);
        check("rst_tx_count", 32'(tx_count), 32'd0);
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
        check("rst_start_tx", 32'(start_tx), 32'd0);
        check("rst_tx_value", 32'(tx_value), 32'd0);
        check("rst_rx_clear", 32'(rx_clear), 32'd0);
        check("rst_rx_rd_data", 32'(rx_rd_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] t1 [3];

    initial begin
        t1 = '{8'h55, 8'hA3, 8'h0F};
        rst = 1'b1; tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0;
        rx_ovr_clr = 1'b0; rx_available = 1'b0; rx_value = '0;
        step();
        step();
        check_reset_state();
        rst = 1'b0;
        step();

        // Three back-to-back frames, with write-to-start latency.
        for (int i = 0; i < 3; i++) begin
            tx_wr_en   = 1'b1;
            tx_wr_data = t1[i];
            tx_exp_q.push_back(t1[i]);
            step();
            if (i == 0) begin
                check("tx_count_n1", 32'(tx_count), 32'd1);
                check("start_n1", 32'(start_tx), 32'd0);
            end
            if (i == 1) check("start_n2", 32'(start_tx), 32'd1);
        end
        tx_wr_en = 1'b0;
        wait_tx_drain();
        check("tx_frames3", 32'(tx_frames), 32'd3);

        // TX fill while the core stalls: one byte in flight, four queued, fifth dropped.
        uart_block = 1'b1;
        tx_frames  = 0;
        tx_exp_q.push_back(8'hC0);
        tx_write(8'hC0);
        wait_start("tx_prime");
        for (int i = 0; i < 5; i++) begin
            if (i < DEPTH) tx_exp_q.push_back(8'hC1 + 8'(i));
            tx_write(8'hC1 + 8'(i));
            if (i == 3) check("tx_full_4", 32'(tx_full), 32'd1);
        end
        check("tx_count_after5", 32'(tx_count), 32'd4);
        repeat (10) step();
        check("tx_count_stall", 32'(tx_count), 32'd4);
        check("tx_full_stall", 32'(tx_full), 32'd1);
        check("start_stall", 32'(start_tx), 32'd1);
        uart_block = 1'b0;
        wait_tx_drain();
        check("tx_frames5", 32'(tx_frames), 32'd5);

        // RX: two bytes, one acknowledgement each, read back in order.
        ack_cnt = 0;
        rx_send(8'h12, 1);
        rx_send(8'h34, 3);
        check("rx_acks", 32'(ack_cnt), 32'd2);
        check("rx_count2", 32'(rx_count), 32'd2);
        rx_read();
        rx_read();
        check("rx_empty_after", 32'(rx_empty), 32'd1);

        // RX overrun: fifth byte dropped, sticky flag, set wins over clear.
        for (int i = 0; i < 5; i++) begin
            rx_send(8'hA0 + 8'(i), 1);
            check("rx_ovr_seq", 32'(rx_overrun), 32'(exp_ovr));
        end
        repeat (5) step();
        check("rx_ovr_sticky", 32'(rx_overrun), 32'd1);
        rx_ovr_clr = 1'b1;
        step();
        rx_ovr_clr = 1'b0;
        check("rx_ovr_clr", 32'(rx_overrun), 32'd0);
        rx_ovr_clr   = 1'b1;
        rx_available = 1'b1;
        rx_value     = 8'hA5;
        step();
        rx_ovr_clr   = 1'b0;
        check("rx_ovr_setwins", 32'(rx_overrun), 32'd1);
        rx_available = 1'b0;
        step();
        check("rx_ovr_hold", 32'(rx_overrun), 32'd1);
        check("rx_count_full", 32'(rx_count), 32'd4);
        rx_ovr_clr = 1'b1;
        step();
        rx_ovr_clr = 1'b0;
        for (int i = 0; i < 4; i++) rx_read();
        check("rx_empty_drained", 32'(rx_empty), 32'd1);

        // Simultaneous read and incoming byte at count 2.
        rx_send(8'hB0, 1);
        rx_send(8'hB1, 1);
        check("rx_count_pre", 32'(rx_count), 32'd2);
        check("rx_head_sim", 32'(rx_rd_data), 32'(rx_exp_q.pop_front()));
        rx_exp_q.push_back(8'hB2);
        rx_available = 1'b1;
        rx_value     = 8'hB2;
        rx_rd_en     = 1'b1;
        step();
        rx_rd_en     = 1'b0;
        rx_available = 1'b0;
        check("rx_count_sim", 32'(rx_count), 32'd2);
        step();
        rx_read();
        rx_read();
        check("rx_empty_sim", 32'(rx_empty), 32'd1);

        // Reset in the middle of a frame with data queued on both sides.
        uart_block = 1'b1;
        tx_write(8'hD0);
        wait_start("tx_send_rst");
        tx_write(8'hD1);
        rx_send(8'hE0, 1);
        check("pre_rst_tx_count", 32'(tx_count), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tx_exp_q.delete();
        rx_exp_q.delete();
        check_reset_state();
        repeat (3) step();
        check("post_rst_start", 32'(start_tx), 32'd0);
        uart_block = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Buffering and handshake controller between the CPU-side peripheral registers and the `uart` core. It holds outgoing bytes in a TX FIFO and drives the core's `start_tx`/`tx_done` handshake, one byte per frame. It drains the core's `rx_available`/`rx_clear` handshake into an RX FIFO, so received bytes are not lost while software is busy. Two synchronous FIFOs and two small handshake FSMs; no baud logic, which stays in `uart`.

## Interface
Reset is synchronous and active-high; the clock port is `clk` and the reset port is `rst`.

**Parameters**
- DEPTH, 4: entries per FIFO; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counts.

**Ports**
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous active-high reset.
- tx_wr_en  in  1  push `tx_wr_data` into the TX FIFO.
- tx_wr_data  in  8  byte to transmit.
- tx_full  out  1  TX FIFO full.
- tx_count  out  CNT_W  TX occupancy.
- rx_rd_en  in  1  pop the RX FIFO head.
- rx_rd_data  out  8  RX FIFO head (first-word fall-through).
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  CNT_W  RX occupancy.
- rx_overrun  out  1  sticky flag: a byte was dropped because the RX FIFO was full.
- rx_ovr_clr  in  1  clears `rx_overrun`.
- start_tx  out  1  to `uart`: request and hold a frame.
- tx_value  out  8  to `uart`: byte for the frame; held stable while `start_tx`=1.
- tx_done  in  1  from `uart`: frame complete.
- rx_available  in  1  from `uart`: received byte valid.
- rx_value  in  8  from `uart`: received byte.
- rx_clear  out  1  to `uart`: acknowledge the received byte.

## Operation
**Reset values**
- FIFOs empty, counts 0, `tx_full`=0, `rx_empty`=1.
- `rx_overrun`=0, `start_tx`=0, `tx_value`=0, `rx_clear`=0, `rx_rd_data`=0.
- Both FSMs go to IDLE.
- Reset mid-frame drops `start_tx` the next cycle. The `uart` core shares the reset, so no frame is left half-sent in the core.

**FIFOs**
- Circular buffers with `$clog2(DEPTH)`-bit pointers that wrap naturally; the count is kept separately.
- Full means count==DEPTH; empty means count==0. Both are decided on the registered count.
- Push when full is ignored on the TX side. On the RX side it is ignored and sets `rx_overrun`.
- Pop when empty is ignored.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Push on full is still rejected even if a pop happens in the same cycle.
- Pop on empty is rejected even if a push happens in the same cycle.

**TX FSM (T_IDLE, T_SEND, T_RELEASE)**
- T_IDLE: if the TX FIFO is not empty, pop the head into `tx_value`, set `start_tx`=1, go to T_SEND.
- T_SEND: hold `start_tx`=1 and `tx_value`. When `tx_done`=1, set `start_tx`=0 and go to T_RELEASE.
- T_RELEASE: wait for `tx_done`=0, then go to T_IDLE.
- Exactly one pop per frame. Back-to-back frames are separated by at least the release cycles.

**RX FSM (R_IDLE, R_ACK)**
- R_IDLE: when `rx_available`=1, push `rx_value`, set `rx_clear`=1, go to R_ACK.
- R_ACK: hold `rx_clear`=1 until `rx_available`=0, then set `rx_clear`=0 and go to R_IDLE.
- Each `rx_available` assertion produces exactly one push attempt.
- `rx_ovr_clr` and a new overrun in the same cycle leave `rx_overrun`=1 (set wins).

## Timing
- `tx_wr_en` in cycle N: `tx_count`/`tx_full` update at N+1, and `start_tx` rises at N+2 if the TX FSM is idle.
- `tx_done` high in cycle N: `start_tx` is low at N+1.
- `rx_available` high in cycle N: the byte is visible on `rx_rd_data` with `rx_empty`=0 at N+1, and `rx_clear` is high at N+1.
- `rx_rd_en` in cycle N: the next head appears at N+1.
- All outputs are registered except `rx_rd_data`, `tx_full` and `rx_empty`, which are decoded from registers with no input-to-output combinational path.

## Structure
- Shared package `uart_pkg`: TX/RX FSM state encodings (one-hot localparams), the `DEPTH` default, and the baud divisor constants shared with `uart`.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH; ports push, pop, data in/out, full, empty, count), instantiated twice: 8-bit TX and 8-bit RX.
- The FSMs live in `uart_fifo_ctrl`.

## Test plan
- Write 0x55, 0xA3, 0x0F back-to-back against a `uart` behavioural model that asserts `tx_done` 20 cycles after `start_tx` → three frames in order; `tx_value` stable throughout each `start_tx` high; `start_tx` low between frames.
- Write 5 bytes with DEPTH=4 while the TX FSM is blocked (`tx_done` held 0) → `tx_full`=1 after 4 writes; the fifth byte is dropped; `tx_count`=4 while the stall lasts.
- Model delivers 0x12, 0x34 on `rx_available` → `rx_clear` acknowledges each once; `rx_count`=2; reads return 0x12 then 0x34; `rx_empty`=1 afterwards.
- Deliver 5 bytes with no reads (DEPTH=4) → fifth byte dropped; `rx_overrun`=1 until `rx_ovr_clr`; contents equal the first four bytes; `rx_overrun` stays set if `rx_ovr_clr` coincides with a sixth drop.
- Simultaneous `rx_rd_en` and an incoming byte at `rx_count`=2 → count stays 2, order preserved; assert `rst` during T_SEND → `start_tx`=0, counts 0, `rx_empty`=1 on the next cycle.
